myniosiicpu_led_sequencer: RTL and testbench



---
 rtl/myniosiicpu_led_seq_pkg.sv | 33 +++
 rtl/myniosiicpu_led_seq_regs.sv | 132 +++++++++++++
 rtl/myniosiicpu_led_sequencer.sv | 174 +++++++++++++++++
 tb/tb_myniosiicpu_led_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/myniosiicpu_led_seq_pkg.sv
// Shared definitions for the LED sequencer: slave register map, CTRL/STATUS
// bit positions and the sequencer FSM state encoding.
package myniosiicpu_led_seq_pkg;

   // Slave word addresses
   localparam logic [3:0] ADDR_CTRL       = 4'd0;
   localparam logic [3:0] ADDR_STATUS     = 4'd1;
   localparam logic [3:0] ADDR_PERIOD     = 4'd2;
   localparam logic [3:0] ADDR_LEN        = 4'd3;
   localparam logic [3:0] ADDR_DIRECT     = 4'd4;
   localparam logic [3:0] ADDR_TABLE_BASE = 4'd8;

   // CTRL bits
   localparam int CTRL_RUN    = 0;
   localparam int CTRL_LOOP   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // STATUS bits
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_IDX_LSB = 4;

   // LEN keeps the full written word so that any value above DEPTH clamps
   localparam int LEN_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WR    = 2'd1,
      S_WAIT  = 2'd2,
      S_DIRWR = 2'd3
   } seq_state_e;

endpackage

// File: rtl/myniosiicpu_led_seq_regs.sv
// CPU-facing register file of the LED sequencer: slave decode, CTRL/STATUS/
// PERIOD/LEN/DIRECT registers, the pattern table, the readdata mux and the
// DIRECT-pending flag. Optional macro LED_SEQ_IRQ_EN implements CTRL.IRQ_EN;
// without it that bit reads 0 and the interrupt enable is tied low.
// Only the first 8 table entries are reachable through the 4-bit address.
module myniosiicpu_led_seq_regs
   import myniosiicpu_led_seq_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int LED_W    = 8,
   parameter int PERIOD_W = 24,
   localparam int IDX_W   = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   input  logic                busy,
   input  logic [IDX_W-1:0]    cur_idx,
   input  logic [IDX_W-1:0]    pat_idx,
   input  logic                run_clr,
   input  logic                done_set,
   input  logic                dir_clr,
   output logic                run,
   output logic                run_start,
   output logic                loop,
   output logic                irq_en,
   output logic                done,
   output logic                dir_pend,
   output logic [PERIOD_W-1:0] period_eff,
   output logic [IDX_W:0]      len_eff,
   output logic [LED_W-1:0]    direct,
   output logic [LED_W-1:0]    pat_data
);

   logic                         wr;
   logic                         tbl_hit;
   logic [IDX_W-1:0]             tbl_idx;
   logic [PERIOD_W-1:0]          period;
   logic [LEN_W-1:0]             len;
   logic [DEPTH-1:0][LED_W-1:0]  tbl;

   assign wr        = chipselect & ~write_n;
   assign tbl_hit   = (address >= ADDR_TABLE_BASE) &&
                      ({28'd0, address - ADDR_TABLE_BASE} < 32'(DEPTH));
   assign tbl_idx   = IDX_W'(address - ADDR_TABLE_BASE);
   assign run_start = wr && (address == ADDR_CTRL) && writedata[CTRL_RUN];

   // PERIOD 0 behaves as 1; LEN 0 or above DEPTH means the full table
   assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
   assign len_eff    = ((len == '0) || (len > LEN_W'(DEPTH))) ? (IDX_W+1)'(DEPTH)
                                                              : len[IDX_W:0];
   assign pat_data   = tbl[pat_idx];

   // Register file; a CPU CTRL write wins over the FSM clearing RUN, and a
   // DONE set wins over a same-cycle write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         run      <= 1'b0;
         loop     <= 1'b0;
         done     <= 1'b0;
         dir_pend <= 1'b0;
         period   <= '0;
         len      <= '0;
         direct   <= '0;
         tbl      <= '0;
      end else begin
         if (wr && address == ADDR_CTRL) begin
            run  <= writedata[CTRL_RUN];
            loop <= writedata[CTRL_LOOP];
         end else if (run_clr) begin
            run <= 1'b0;
         end
         if (done_set)
            done <= 1'b1;
         else if (wr && address == ADDR_STATUS && writedata[STAT_DONE])
            done <= 1'b0;
         if (wr && address == ADDR_PERIOD) period <= writedata[PERIOD_W-1:0];
         if (wr && address == ADDR_LEN)    len    <= writedata;
         if (wr && address == ADDR_DIRECT) direct <= writedata[LED_W-1:0];
         if (wr && address == ADDR_DIRECT)
            dir_pend <= 1'b1;
         else if (dir_clr)
            dir_pend <= 1'b0;
         if (wr && tbl_hit) tbl[tbl_idx] <= writedata[LED_W-1:0];
      end
   end

`ifdef LED_SEQ_IRQ_EN
   logic irq_en_q;

   // Interrupt enable bit, only present in interrupt-capable builds
   always_ff @(posedge clk) begin
      if (reset)
         irq_en_q <= 1'b0;
      else if (wr && address == ADDR_CTRL)
         irq_en_q <= writedata[CTRL_IRQ_EN];
   end
   assign irq_en = irq_en_q;
`else
   assign irq_en = 1'b0;
`endif

   // Zero-wait-state read mux; unmapped addresses return 0
   always_comb begin
      readdata = '0;
      if (tbl_hit) begin
         readdata[LED_W-1:0] = tbl[tbl_idx];
      end else begin
         case (address)
            ADDR_CTRL: begin
               readdata[CTRL_RUN]    = run;
               readdata[CTRL_LOOP]   = loop;
               readdata[CTRL_IRQ_EN] = irq_en;
            end
            ADDR_STATUS: begin
               readdata[STAT_BUSY]             = busy;
               readdata[STAT_DONE]             = done;
               readdata[STAT_IDX_LSB +: 4]     = 4'(cur_idx);
            end
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
            ADDR_LEN:    readdata               = len;
            ADDR_DIRECT: readdata[LED_W-1:0]    = direct;
            default:     readdata               = '0;
         endcase
      end
   end

endmodule

// File: rtl/myniosiicpu_led_sequencer.sv
// LED sequencer top: sole Avalon-MM master of the LED PIO s1 port. Steps
// through the pattern table at the programmed period, or forwards DIRECT
// writes while stopped. Optional macro LED_SEQ_IRQ_EN enables irq = DONE &
// IRQ_EN; otherwise irq is tied 0 and DONE is for polling only.
module myniosiicpu_led_sequencer
   import myniosiicpu_led_seq_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int LED_W    = 8,
   parameter int PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        irq
);

   localparam int IDX_W = $clog2(DEPTH);

   seq_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d, idx_inc, pat_idx;
   logic [IDX_W:0]      idx_nxt_w, len_eff;
   logic [PERIOD_W-1:0] cnt_q, cnt_d, period_eff;
   logic [LED_W-1:0]    wdata_q, wdata_d, pat_data, direct;
   logic                run, run_start, loop, irq_en, done, dir_pend;
   logic                run_clr, done_set, dir_clr, expire, more, busy;

   myniosiicpu_led_seq_regs #(
      .DEPTH    (DEPTH),
      .LED_W    (LED_W),
      .PERIOD_W (PERIOD_W)
   ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .busy       (busy),
      .cur_idx    (idx_q),
      .pat_idx    (pat_idx),
      .run_clr    (run_clr),
      .done_set   (done_set),
      .dir_clr    (dir_clr),
      .run        (run),
      .run_start  (run_start),
      .loop       (loop),
      .irq_en     (irq_en),
      .done       (done),
      .dir_pend   (dir_pend),
      .period_eff (period_eff),
      .len_eff    (len_eff),
      .direct     (direct),
      .pat_data   (pat_data)
   );

   assign busy      = (state_q != S_IDLE);
   assign idx_nxt_w = {1'b0, idx_q} + (IDX_W+1)'(1);
   assign idx_inc   = idx_nxt_w[IDX_W-1:0];
   assign more      = (idx_nxt_w < len_eff);
   // Table entry for the next WR; it only differs from 0 when advancing
   assign pat_idx   = (state_q != S_IDLE && more) ? idx_inc : '0;
   assign irq       = done & irq_en;

   // State, index, period counter and the latched PIO data
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
      end
   end

   // Next-state logic. The accept cycle counts as the first cycle of the
   // period, so WAIT runs PERIOD-1 cycles and PERIOD 1 skips WAIT entirely;
   // that keeps accept-to-next-present at exactly max(PERIOD,1).
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      wdata_d  = wdata_q;
      run_clr  = 1'b0;
      done_set = 1'b0;
      dir_clr  = 1'b0;
      expire   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run || run_start) begin
               state_d = S_WR;
               idx_d   = '0;
               wdata_d = pat_data;
            end else if (dir_pend) begin
               state_d = S_DIRWR;
               wdata_d = direct;
            end
         end
         S_WR: begin
            if (!m_waitrequest) begin
               if (!run)
                  state_d = S_IDLE;
               else if (period_eff == PERIOD_W'(1))
                  expire = 1'b1;
               else begin
                  cnt_d   = period_eff - PERIOD_W'(1);
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!run)
               state_d = S_IDLE;
            else if (cnt_q == PERIOD_W'(1))
               expire = 1'b1;
            else
               cnt_d = cnt_q - PERIOD_W'(1);
         end
         S_DIRWR: begin
            if (!m_waitrequest) begin
               dir_clr = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (expire) begin
         if (more) begin
            idx_d   = idx_inc;
            state_d = S_WR;
            wdata_d = pat_data;
         end else if (loop) begin
            idx_d   = '0;
            state_d = S_WR;
            wdata_d = pat_data;
         end else begin
            run_clr  = 1'b1;
            done_set = 1'b1;
            state_d  = S_IDLE;
         end
      end
   end

   // Master port: a write is presented only in WR and DIRWR
   always_comb begin
      m_chipselect = 1'b0;
      m_write_n    = 1'b1;
      case (state_q)
         S_WR, S_DIRWR: begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
         end
         default: ;
      endcase
   end

   assign m_address   = 2'd0;
   assign m_writedata = {{(32-LED_W){1'b0}}, wdata_q};

endmodule

// File: tb/tb_myniosiicpu_led_sequencer.sv
// Directed bench for the LED sequencer with a PIO model logging every
// accepted write (data and cycle number).
module tb_myniosiicpu_led_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [1:0]  m_address;
   logic        m_chipselect, m_write_n;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b0;
   logic        irq;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          nw = 0;
   logic [31:0] wlog_d [0:63];
   int          wlog_t [0:63];
   logic [31:0] led = '0;

   always #5 clk = ~clk;

   myniosiicpu_led_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .chipselect    (chipselect),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .m_address     (m_address),
      .m_chipselect  (m_chipselect),
      .m_write_n     (m_write_n),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest),
      .irq           (irq)
   );

   // PIO model: latch and log each accepted write
   always @(posedge clk) begin
      if (!reset && m_chipselect && !m_write_n && !m_waitrequest && nw < 64) begin
         wlog_d[nw] = m_writedata;
         wlog_t[nw] = cyc;
         nw = nw + 1;
         led = m_writedata;
      end
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic cpu_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      #1 d = readdata;
   endtask

   initial begin
      logic [31:0] rd;
      int b, k, n, first;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cs", {31'd0, m_chipselect}, 0);
      chk("rst_wn", {31'd0, m_write_n}, 1);
      chk("rst_wd", m_writedata, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      reset = 1'b0;
      cpu_rd(4'd0, rd); chk("rst_ctrl", rd, 0);
      cpu_rd(4'd1, rd); chk("rst_status", rd, 0);
      cpu_rd(4'd5, rd); chk("unmapped", rd, 0);

      // Single pass: PERIOD 4, LEN 3, {01,02,04}
      cpu_wr(4'd2, 4); cpu_wr(4'd3, 3);
      cpu_wr(4'd8, 8'h01); cpu_wr(4'd9, 8'h02); cpu_wr(4'd10, 8'h04);
      b = nw; cpu_wr(4'd0, 1); k = cyc;
      repeat (30) @(negedge clk);
      chk("t1_nw", nw - b, 3);
      chk("t1_d0", wlog_d[b], 8'h01);
      chk("t1_d1", wlog_d[b+1], 8'h02);
      chk("t1_d2", wlog_d[b+2], 8'h04);
      chk("t1_lat", wlog_t[b] - k, 0);
      chk("t1_gap1", wlog_t[b+1] - wlog_t[b], 4);
      chk("t1_gap2", wlog_t[b+2] - wlog_t[b+1], 4);
      cpu_rd(4'd1, rd); chk("t1_status", rd, 32'h22);
      chk("t1_led", led, 8'h04);
      cpu_wr(4'd1, 2);
      cpu_rd(4'd1, rd); chk("t1_doneclr", rd, 32'h20);

      // Loop {AA,55}, then stop during WAIT
      cpu_wr(4'd3, 2); cpu_wr(4'd8, 8'hAA); cpu_wr(4'd9, 8'h55);
      b = nw; cpu_wr(4'd0, 3);
      n = 0;
      while (nw - b < 5 && n < 200) begin @(negedge clk); n++; end
      chk("t2_timeout", {31'd0, n < 200}, 1);
      chk("t2_d0", wlog_d[b], 8'hAA);
      chk("t2_d1", wlog_d[b+1], 8'h55);
      chk("t2_d2", wlog_d[b+2], 8'hAA);
      chk("t2_d3", wlog_d[b+3], 8'h55);
      chk("t2_d4", wlog_d[b+4], 8'hAA);
      cpu_wr(4'd0, 2);
      repeat (20) @(negedge clk);
      chk("t2_nw", nw - b, 5);
      cpu_rd(4'd1, rd); chk("t2_status", rd, 32'h00);

      // Stall the first WR for 3 cycles
      cpu_wr(4'd0, 0);
      @(negedge clk); m_waitrequest = 1'b1;
      b = nw; cpu_wr(4'd0, 1); k = cyc;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) m_waitrequest = 1'b0;
         chk($sformatf("t3_hold%0d", i), {m_chipselect, m_write_n, 22'd0, m_writedata[7:0]},
             {2'b10, 22'd0, 8'hAA});
         @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("t3_nw", nw - b, 2);
      chk("t3_d0", wlog_d[b], 8'hAA);
      chk("t3_d1", wlog_d[b+1], 8'h55);
      chk("t3_lat", wlog_t[b] - k, 3);
      chk("t3_gap", wlog_t[b+1] - wlog_t[b], 4);
      cpu_wr(4'd1, 2);

      // DIRECT while running is deferred until the sequence ends
      cpu_wr(4'd3, 3); cpu_wr(4'd10, 8'h04);
      b = nw; cpu_wr(4'd0, 1); cpu_wr(4'd4, 8'h3C);
      repeat (40) @(negedge clk);
      chk("t4_nw", nw - b, 4);
      chk("t4_d2", wlog_d[b+2], 8'h04);
      chk("t4_d3", wlog_d[b+3], 8'h3C);
      chk("t4_led", led, 8'h3C);
      cpu_rd(4'd4, rd); chk("t4_direct", rd, 8'h3C);
      cpu_rd(4'd1, rd); chk("t4_status", rd, 32'h22);
      cpu_wr(4'd1, 2);

      // PERIOD 0 acts as 1, LEN 20 clamps to 8
      cpu_wr(4'd2, 0); cpu_wr(4'd3, 20);
      b = nw; cpu_wr(4'd0, 1);
      repeat (30) @(negedge clk);
      chk("t5_nw", nw - b, 8);
      chk("t5_d1", wlog_d[b+1], 8'h55);
      chk("t5_gap", wlog_t[b+1] - wlog_t[b], 1);
      chk("t5_span", wlog_t[b+7] - wlog_t[b], 7);
      cpu_rd(4'd2, rd); chk("t5_period", rd, 0);
      cpu_rd(4'd3, rd); chk("t5_len", rd, 20);
      cpu_rd(4'd1, rd); chk("t5_status", rd, 32'h72);
      cpu_wr(4'd1, 2);

      // Interrupt
      cpu_wr(4'd2, 2); cpu_wr(4'd3, 1); cpu_wr(4'd0, 4);
      cpu_rd(4'd0, rd);
`ifdef LED_SEQ_IRQ_EN
      chk("t6_ctrl", rd, 4);
`else
      chk("t6_ctrl", rd, 0);
`endif
      b = nw; cpu_wr(4'd0, 5);
      first = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (irq && first < 0) first = cyc;
      end
      cpu_rd(4'd1, rd); chk("t6_status", rd, 32'h02);
`ifdef LED_SEQ_IRQ_EN
      chk("t6_irq_rise", first - wlog_t[b], 2);
      cpu_wr(4'd1, 2);
      chk("t6_irq_drop", {31'd0, irq}, 0);
`else
      chk("t6_irq_tied", first, -1);
      cpu_wr(4'd1, 2);
`endif

      // Reset in the middle of a stalled WR
      cpu_wr(4'd2, 3); cpu_wr(4'd8, 8'h77);
      @(negedge clk); m_waitrequest = 1'b1;
      b = nw; cpu_wr(4'd0, 1);
      chk("t7_inwr", {m_chipselect, m_write_n, 22'd0, m_writedata[7:0]}, {2'b10, 22'd0, 8'h77});
      reset = 1'b1;
      @(negedge clk);
      chk("t7_out", {m_chipselect, m_write_n, 22'd0, m_writedata[7:0]}, {2'b01, 30'd0});
      m_waitrequest = 1'b0; reset = 1'b0;
      cpu_rd(4'd0, rd); chk("t7_ctrl", rd, 0);
      cpu_rd(4'd2, rd); chk("t7_period", rd, 0);
      cpu_rd(4'd8, rd); chk("t7_tbl0", rd, 0);
      cpu_rd(4'd1, rd); chk("t7_status", rd, 0);
      repeat (5) @(negedge clk);
      chk("t7_nw", nw - b, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
